// File: rtl/fwrisc_bus_pkg.sv
// Shared definitions for the fwrisc bus arbiter: arbitration mode codes and
// the controller state encoding.
package fwrisc_bus_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fwrisc_rr_arb.sv
// Combinational one-hot picker. The request vector is doubled and rotated
// right by the start index, so the lowest set bit of the low half is the
// first requester at or after the start position. That single-bit mask is
// rotated back to give the grant. In fixed mode the start index is forced
// to zero, which reduces the search to plain lowest-index priority.
module fwrisc_rr_arb
  import fwrisc_bus_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             mode,
  output logic [N-1:0]     gnt
);

  logic [PTR_W-1:0] start;
  logic [2*N-1:0]   dbl_req;
  logic [N-1:0]     rot;
  logic [N-1:0]     low;
  logic [2*N-1:0]   dbl_gnt;

  // rotate, isolate the lowest set bit, rotate back
  always_comb begin
    start   = mode ? ptr : '0;
    dbl_req = {req, req};
    rot     = N'(dbl_req >> start);
    low     = rot & (-rot);
    dbl_gnt = {{N{1'b0}}, low} << start;
    gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
  end

endmodule

// File: rtl/fwrisc_bus_arb.sv
// N-port arbiter merging valid/ready memory request ports onto one shared
// memory port. One transaction outstanding at a time.
//
// Handshake (both sides): a requester raises valid with addr/wdata/wstb/write
// and holds them stable until it sees ready; ready is a single-cycle
// completion pulse and read data is valid in that same cycle. On the request
// side the arbiter latches the winner in IDLE, so m_* come from registers
// and stay stable for the whole BUSY phase even if the requester drops
// valid. m_ready in BUSY is forwarded combinationally as req_ready to the
// latched grant only; m_ready seen in IDLE is ignored.
module fwrisc_bus_arb
  import fwrisc_bus_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_PORTS-1:0]                  req_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]       req_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   req_wstb,
  input  logic [NUM_PORTS-1:0]                  req_write,
  output logic [NUM_PORTS-1:0]                  req_ready,
  output logic [DATA_WIDTH-1:0]                 req_rdata,
  output logic                                  m_valid,
  output logic [ADDR_WIDTH-1:0]                 m_addr,
  output logic [DATA_WIDTH-1:0]                 m_wdata,
  output logic [DATA_WIDTH/8-1:0]               m_wstb,
  output logic                                  m_write,
  input  logic [DATA_WIDTH-1:0]                 m_rdata,
  input  logic                                  m_ready
);

  localparam int   STB_W   = DATA_WIDTH / 8;
  localparam int   PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic MODE_RR = (ARB_MODE == ARB_RR);

  arb_state_e           state;
  arb_state_e           state_next;
  logic                 take;
  logic                 done;
  logic [NUM_PORTS-1:0] pick;
  logic [NUM_PORTS-1:0] grant;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     ptr_after;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STB_W-1:0]      sel_wstb;
  logic                  sel_write;

  fwrisc_rr_arb #(
    .N     (NUM_PORTS),
    .PTR_W (PTR_W)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .mode (MODE_RR),
    .gnt  (pick)
  );

  // select the winning port's request fields (pick is one-hot or zero)
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstb  = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick[i]) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wstb  = req_wstb[i*STB_W +: STB_W];
        sel_write = req_write[i];
      end
    end
  end

  // round-robin search resumes one past the port just granted, wrapping
  always_comb begin
    ptr_after = rr_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick[i]) ptr_after = PTR_W'((i + 1) % NUM_PORTS);
    end
  end

  // next-state: grant from IDLE, complete from BUSY on m_ready
  always_comb begin
    state_next = state;
    take       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          take       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (m_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // latch the winner's request, grant and advance the pointer on each grant
  always_ff @(posedge clock) begin
    if (reset) begin
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstb  <= '0;
      m_write <= 1'b0;
      grant   <= '0;
      rr_ptr  <= '0;
    end else if (take) begin
      m_addr  <= sel_addr;
      m_wdata <= sel_wdata;
      m_wstb  <= sel_wstb;
      m_write <= sel_write;
      grant   <= pick;
      rr_ptr  <= ptr_after;
    end
  end

  assign m_valid   = (state == BUSY);
  assign req_ready = done ? grant : '0;
  assign req_rdata = m_rdata;

endmodule

// File: tb/tb_fwrisc_bus_arb.sv
// Directed bench for fwrisc_bus_arb: a 4-port round-robin instance and a
// 2-port fixed-priority instance, each with a simple memory responder,
// a requester auto-release process and a completion monitor that pops an
// expected queue of {gap, port, rdata}.
module tb_fwrisc_bus_arb;
  import fwrisc_bus_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  // ---------------- round-robin instance (4 ports) ----------------
  logic [3:0]   rr_req_valid, rr_req_write, rr_req_ready, rr_sticky, rr_done;
  logic [127:0] rr_req_addr, rr_req_wdata;
  logic [15:0]  rr_req_wstb;
  logic [31:0]  rr_req_rdata, rr_m_addr, rr_m_wdata, rr_m_rdata, rr_fixed_data;
  logic [3:0]   rr_m_wstb;
  logic         rr_m_valid, rr_m_write, rr_m_ready, rr_mem_en, rr_use_fixed;
  int           rr_lat, rr_wait, rr_last;
  logic [39:0]  rr_q[$];

  // ---------------- fixed-priority instance (2 ports) ----------------
  logic [1:0]   fx_req_valid, fx_req_write, fx_req_ready, fx_sticky, fx_done;
  logic [63:0]  fx_req_addr, fx_req_wdata;
  logic [7:0]   fx_req_wstb;
  logic [31:0]  fx_req_rdata, fx_m_addr, fx_m_wdata, fx_m_rdata;
  logic [3:0]   fx_m_wstb;
  logic         fx_m_valid, fx_m_write, fx_m_ready;
  int           fx_wait, fx_last;
  logic [39:0]  fx_q[$];

  fwrisc_bus_arb #(
    .NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(ARB_RR)
  ) dut_rr (
    .clock(clock), .reset(reset),
    .req_valid(rr_req_valid), .req_addr(rr_req_addr), .req_wdata(rr_req_wdata),
    .req_wstb(rr_req_wstb), .req_write(rr_req_write), .req_ready(rr_req_ready),
    .req_rdata(rr_req_rdata), .m_valid(rr_m_valid), .m_addr(rr_m_addr),
    .m_wdata(rr_m_wdata), .m_wstb(rr_m_wstb), .m_write(rr_m_write),
    .m_rdata(rr_m_rdata), .m_ready(rr_m_ready)
  );

  fwrisc_bus_arb #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(ARB_FIXED)
  ) dut_fx (
    .clock(clock), .reset(reset),
    .req_valid(fx_req_valid), .req_addr(fx_req_addr), .req_wdata(fx_req_wdata),
    .req_wstb(fx_req_wstb), .req_write(fx_req_write), .req_ready(fx_req_ready),
    .req_rdata(fx_req_rdata), .m_valid(fx_m_valid), .m_addr(fx_m_addr),
    .m_wdata(fx_m_wdata), .m_wstb(fx_m_wstb), .m_write(fx_m_write),
    .m_rdata(fx_m_rdata), .m_ready(fx_m_ready)
  );

  // ---------------- clock / cycle counter / watchdog ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [39:0] mk(input logic [3:0] gap, input logic [3:0] port,
                                     input logic [31:0] data);
    return {gap, port, data};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic set_rr(input int p, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s);
    rr_req_addr[p*32 +: 32]  = a;
    rr_req_wdata[p*32 +: 32] = d;
    rr_req_wstb[p*4 +: 4]    = s;
    rr_req_write[p]          = w;
    rr_req_valid[p]          = 1'b1;
  endtask

  task automatic set_fx(input int p, input logic [31:0] a);
    fx_req_addr[p*32 +: 32]  = a;
    fx_req_wdata[p*32 +: 32] = 32'h0;
    fx_req_wstb[p*4 +: 4]    = 4'h0;
    fx_req_write[p]          = 1'b0;
    fx_req_valid[p]          = 1'b1;
  endtask

  task automatic wait_rr(input int n, input int budget);
    int k;
    k = 0;
    while (rr_q.size() > n && k < budget) begin
      step();
      k++;
    end
    chk("rr_pending", 64'(rr_q.size()), 64'(n));
    if (rr_q.size() > n) rr_q.delete();
  endtask

  task automatic wait_fx(input int n, input int budget);
    int k;
    k = 0;
    while (fx_q.size() > n && k < budget) begin
      step();
      k++;
    end
    chk("fx_pending", 64'(fx_q.size()), 64'(n));
    if (fx_q.size() > n) fx_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- memory responders ----------------
  initial begin
    rr_m_ready = 1'b0;
    rr_m_rdata = '0;
    rr_wait    = 0;
    forever begin
      @(posedge clock);
      #1;
      rr_m_ready = 1'b0;
      if (rr_m_valid === 1'b1 && !reset && rr_mem_en) begin
        if (rr_wait >= rr_lat) begin
          rr_m_ready = 1'b1;
          rr_m_rdata = rr_use_fixed ? rr_fixed_data : (rr_m_addr ^ 32'h5A5A_0000);
          rr_wait    = 0;
        end else begin
          rr_wait++;
        end
      end else begin
        rr_wait = 0;
      end
    end
  end

  initial begin
    fx_m_ready = 1'b0;
    fx_m_rdata = '0;
    fx_wait    = 0;
    forever begin
      @(posedge clock);
      #1;
      fx_m_ready = 1'b0;
      if (fx_m_valid === 1'b1 && !reset) begin
        fx_m_ready = 1'b1;
        fx_m_rdata = fx_m_addr ^ 32'h5A5A_0000;
      end
    end
  end

  // ---------------- requester release: drop valid after ready ----------------
  initial begin
    forever begin
      @(negedge clock);
      rr_done = rr_req_ready & ~rr_sticky;
      fx_done = fx_req_ready & ~fx_sticky;
      @(posedge clock);
      #1;
      rr_req_valid = rr_req_valid & ~rr_done;
      fx_req_valid = fx_req_valid & ~fx_done;
    end
  end

  // ---------------- monitors / scoreboard ----------------
  initial begin
    logic [39:0] e;
    rr_last = 0;
    forever begin
      @(negedge clock);
      if (|rr_req_ready) begin
        if (rr_q.size() == 0) begin
          chk("rr_unexpected_ready", 64'(rr_req_ready), 64'h0);
        end else begin
          e = rr_q.pop_front();
          chk("rr_grant", 64'(rr_req_ready), 64'h1 << e[35:32]);
          chk("rr_rdata", 64'(rr_req_rdata), 64'(e[31:0]));
          if (e[39:36] != 4'd0) chk("rr_gap", 64'(cyc - rr_last), 64'(e[39:36]));
        end
        rr_last = cyc;
      end
    end
  end

  initial begin
    logic [39:0] e;
    fx_last = 0;
    forever begin
      @(negedge clock);
      if (|fx_req_ready) begin
        if (fx_q.size() == 0) begin
          chk("fx_unexpected_ready", 64'(fx_req_ready), 64'h0);
        end else begin
          e = fx_q.pop_front();
          chk("fx_grant", 64'(fx_req_ready), 64'h1 << e[35:32]);
          chk("fx_rdata", 64'(fx_req_rdata), 64'(e[31:0]));
          if (e[39:36] != 4'd0) chk("fx_gap", 64'(cyc - fx_last), 64'(e[39:36]));
        end
        fx_last = cyc;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    rr_req_valid = '0; rr_req_write = '0; rr_req_addr = '0; rr_req_wdata = '0;
    rr_req_wstb  = '0; rr_sticky = '0; rr_done = '0;
    fx_req_valid = '0; fx_req_write = '0; fx_req_addr = '0; fx_req_wdata = '0;
    fx_req_wstb  = '0; fx_sticky = '0; fx_done = '0;
    rr_lat = 0; rr_mem_en = 1'b1; rr_use_fixed = 1'b0; rr_fixed_data = '0;

    // reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_m_valid", 64'(rr_m_valid), 64'h0);
    chk("rst_m_addr", 64'(rr_m_addr), 64'h0);
    chk("rst_m_wdata", 64'(rr_m_wdata), 64'h0);
    chk("rst_m_wstb", 64'(rr_m_wstb), 64'h0);
    chk("rst_m_write", 64'(rr_m_write), 64'h0);
    chk("rst_req_ready", 64'(rr_req_ready), 64'h0);
    chk("rst_state", 64'(dut_rr.state), 64'(IDLE));
    chk("rst_grant", 64'(dut_rr.grant), 64'h0);
    chk("rst_fx_m_valid", 64'(fx_m_valid), 64'h0);
    chk("rst_fx_req_ready", 64'(fx_req_ready), 64'h0);
    step();
    reset = 1'b0;

    // single port-0 read, memory answers 0xDEADBEEF after 3 wait cycles
    rr_lat = 3; rr_use_fixed = 1'b1; rr_fixed_data = 32'hDEAD_BEEF;
    rr_q.push_back(mk(4'd0, 4'd0, 32'hDEAD_BEEF));
    set_rr(0, 32'h100, 1'b0, 32'h0, 4'h0);
    @(negedge clock);
    chk("t1_m_valid_before_grant", 64'(rr_m_valid), 64'h0);
    step();
    @(negedge clock);
    chk("t1_m_valid_after_grant", 64'(rr_m_valid), 64'h1);
    chk("t1_m_addr", 64'(rr_m_addr), 64'h100);
    chk("t1_m_write", 64'(rr_m_write), 64'h0);
    wait_rr(0, 20);
    rr_use_fixed = 1'b0;

    // round-robin, all four ports valid, one-cycle memory: 0,1,2,3,0
    do_reset();
    rr_lat = 0;
    rr_sticky = 4'b0001;
    rr_q.push_back(mk(4'd0, 4'd0, 32'h5A5A_0010));
    rr_q.push_back(mk(4'd2, 4'd1, 32'h5A5A_0020));
    rr_q.push_back(mk(4'd2, 4'd2, 32'h5A5A_0030));
    rr_q.push_back(mk(4'd2, 4'd3, 32'h5A5A_0040));
    rr_q.push_back(mk(4'd2, 4'd0, 32'h5A5A_0010));
    for (int i = 0; i < 4; i++) set_rr(i, 32'((i + 1) * 16), 1'b0, 32'h0, 4'h0);
    wait_rr(1, 40);
    rr_sticky = 4'b0000;
    wait_rr(0, 20);

    // write on port 2; requester drops valid mid-transfer
    rr_lat = 4;
    rr_q.push_back(mk(4'd0, 4'd2, 32'h5A5A_0040));
    set_rr(2, 32'h40, 1'b1, 32'h1234_5678, 4'b0011);
    step();
    @(negedge clock);
    chk("t4_m_valid", 64'(rr_m_valid), 64'h1);
    chk("t4_m_addr", 64'(rr_m_addr), 64'h40);
    chk("t4_m_wdata", 64'(rr_m_wdata), 64'h1234_5678);
    chk("t4_m_wstb", 64'(rr_m_wstb), 64'h3);
    chk("t4_m_write", 64'(rr_m_write), 64'h1);
    step();
    rr_req_valid[2] = 1'b0;
    rr_req_addr[95:64]  = 32'hFFFF_FFFF;
    rr_req_wdata[95:64] = 32'h0BAD_0BAD;
    rr_req_wstb[11:8]   = 4'b1100;
    rr_req_write[2]     = 1'b0;
    @(negedge clock);
    chk("t4_hold_m_valid", 64'(rr_m_valid), 64'h1);
    chk("t4_hold_m_addr", 64'(rr_m_addr), 64'h40);
    chk("t4_hold_m_wdata", 64'(rr_m_wdata), 64'h1234_5678);
    chk("t4_hold_m_wstb", 64'(rr_m_wstb), 64'h3);
    chk("t4_hold_m_write", 64'(rr_m_write), 64'h1);
    wait_rr(0, 20);

    // reset while BUSY abandons the transfer and restores port-0 priority
    rr_lat = 6;
    set_rr(1, 32'h80, 1'b0, 32'h0, 4'h0);
    step();
    step();
    @(negedge clock);
    chk("t5_busy_m_valid", 64'(rr_m_valid), 64'h1);
    step();
    reset = 1'b1;
    step();
    rr_req_valid = '0;
    reset = 1'b0;
    @(negedge clock);
    chk("t5_rst_m_valid", 64'(rr_m_valid), 64'h0);
    chk("t5_rst_req_ready", 64'(rr_req_ready), 64'h0);
    chk("t5_rst_state", 64'(dut_rr.state), 64'(IDLE));
    step();
    rr_lat = 0;
    rr_q.push_back(mk(4'd0, 4'd0, 32'h5A5A_0100));
    rr_q.push_back(mk(4'd2, 4'd3, 32'h5A5A_0300));
    set_rr(3, 32'h300, 1'b0, 32'h0, 4'h0);
    set_rr(0, 32'h100, 1'b0, 32'h0, 4'h0);
    wait_rr(0, 30);

    // m_ready pulsed while IDLE is ignored
    rr_mem_en = 1'b0;
    step();
    rr_m_rdata = 32'hBAD0_BAD0;
    rr_m_ready = 1'b1;
    @(negedge clock);
    chk("t6_req_ready", 64'(rr_req_ready), 64'h0);
    chk("t6_state", 64'(dut_rr.state), 64'(IDLE));
    step();
    @(negedge clock);
    chk("t6_state_after", 64'(dut_rr.state), 64'(IDLE));
    chk("t6_m_valid_after", 64'(rr_m_valid), 64'h0);
    rr_mem_en = 1'b1;
    step();

    // fixed priority, both ports valid: 0,0,0 then port 1 once 0 drops
    fx_sticky = 2'b11;
    fx_q.push_back(mk(4'd0, 4'd0, 32'h5A5A_0200));
    fx_q.push_back(mk(4'd2, 4'd0, 32'h5A5A_0200));
    fx_q.push_back(mk(4'd2, 4'd0, 32'h5A5A_0200));
    fx_q.push_back(mk(4'd2, 4'd1, 32'h5A5A_0300));
    set_fx(0, 32'h200);
    set_fx(1, 32'h300);
    wait_fx(2, 30);
    fx_sticky = 2'b00;
    wait_fx(0, 30);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
